// File: rtl/dma_sched_pkg.sv
// Shared types for the DMA command scheduler: FSM states, the latched command record, alignment helper.
// Pure declarations; no latency or backpressure of its own.
package dma_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_st_e;

    // Channel index field sized for the largest supported channel count (16).
    localparam int CH_W = 4;

    typedef struct packed {
        logic [31:0]     sa;
        logic [31:0]     len;
        logic [CH_W-1:0] ch;
        logic            err;
    } dma_cmd_t;

    function automatic logic beat_misaligned(input logic [31:0] addr, input int unsigned l);
        logic [31:0] mask;
        mask = (32'd1 << l) - 32'd1;
        return (addr & mask) != 32'd0;
    endfunction

endpackage

// File: rtl/dma_cmd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or after ptr, wrapping.
// Zero latency; no grant while en is low. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    int          k;
    logic [PW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        k       = 0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            idx = PW'(k);
            if (en && !any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/dma_cmd_sched.sv
// Round-robin DMA command scheduler in front of one burst partitioner; accept -> cfg valid in 1 cycle, ready rise -> done in 1 cycle.
// One command in flight: req_ready stays low outside IDLE, and the cfg command is held until the partitioner accepts it.
module dma_cmd_sched
    import dma_sched_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int AXI_DW = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        req_valid,
    output logic [NCH-1:0]        req_ready,
    input  logic [NCH-1:0][31:0]  req_sa,
    input  logic [NCH-1:0][31:0]  req_len,
    output logic [NCH-1:0]        done,
    output logic [NCH-1:0]        err,
    output logic                  busy,
    output logic                  cfg_dma_valid,
    input  logic                  cfg_dma_ready,
    output logic [31:0]           cfg_dma_sa,
    output logic [31:0]           cfg_dma_len
);

    localparam int L  = $clog2(AXI_DW / 8);
    localparam int PW = $clog2(NCH);

    sched_st_e       state;
    logic [PW-1:0]   rr_ptr;
    dma_cmd_t        cmd;
    logic            seen_busy;

    logic [NCH-1:0]  gnt;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [31:0]     sel_sa;
    logic [31:0]     sel_len;
    logic            sel_zero;
    logic            sel_bad;
    logic [PW-1:0]   ptr_nxt;
    logic [NCH-1:0]  ch_oh;

    rr_arbiter #(
        .N  (NCH),
        .PW (PW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (state == IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    always_comb begin
        sel_sa   = req_sa[gnt_idx];
        sel_len  = req_len[gnt_idx];
        sel_zero = (sel_len == 32'd0);
        // Zero length wins over misalignment: an empty command is a clean no-op.
        sel_bad  = !sel_zero && (beat_misaligned(sel_sa, L) || beat_misaligned(sel_len, L));
        ptr_nxt  = (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + PW'(1);
        ch_oh    = NCH'(1) << cmd.ch;
    end

    assign req_ready   = reset ? '0 : gnt;
    assign busy        = (state != IDLE);
    assign cfg_dma_sa  = cmd.sa;
    assign cfg_dma_len = cmd.len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cmd           <= '0;
            seen_busy     <= 1'b0;
            cfg_dma_valid <= 1'b0;
            done          <= '0;
            err           <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        cmd.sa  <= sel_sa;
                        cmd.len <= sel_len;
                        cmd.ch  <= CH_W'(gnt_idx);
                        cmd.err <= sel_bad;
                        rr_ptr  <= ptr_nxt;
                        if (sel_zero || sel_bad) begin
                            done  <= gnt;
                            err   <= sel_bad ? gnt : '0;
                            state <= RESP;
                        end else begin
                            cfg_dma_valid <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cfg_dma_ready) begin
                        cfg_dma_valid <= 1'b0;
                        seen_busy     <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // Ready straight after the handshake is stale; completion needs a busy period first.
                    if (!cfg_dma_ready) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        done  <= ch_oh;
                        err   <= ch_oh & {NCH{cmd.err}};
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_cmd_sched.sv
// Directed self-checking bench for dma_cmd_sched (NCH=4, AXI_DW=128).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dma_cmd_sched;

    localparam int NCH = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NCH-1:0]       req_valid = '0;
    logic [NCH-1:0]       req_ready;
    logic [NCH-1:0][31:0] req_sa = '0;
    logic [NCH-1:0][31:0] req_len = '0;
    logic [NCH-1:0]       done;
    logic [NCH-1:0]       err;
    logic                 busy;
    logic                 cfg_dma_valid;
    logic                 cfg_dma_ready = 1'b1;
    logic [31:0]          cfg_dma_sa;
    logic [31:0]          cfg_dma_len;

    int n_vec = 0;
    int n_bad = 0;

    dma_cmd_sched #(.NCH(NCH), .AXI_DW(128)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_sa        (req_sa),
        .req_len       (req_len),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .cfg_dma_valid (cfg_dma_valid),
        .cfg_dma_ready (cfg_dma_ready),
        .cfg_dma_sa    (cfg_dma_sa),
        .cfg_dma_len   (cfg_dma_len)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < NCH; i++) begin
            req_sa[i]  = 32'h100 * (i + 1);
            req_len[i] = 32'h40;
        end
        #1;
        n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_vec++; if ({cfg_dma_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL reset_valid_busy: got %b want 00", {cfg_dma_valid, busy}); end
        n_vec++; if ({done, err} !== 8'h00) begin n_bad++; $display("FAIL reset_done_err: got %h want 00", {done, err}); end
        n_vec++; if ({cfg_dma_sa, cfg_dma_len} !== 64'h0) begin n_bad++; $display("FAIL reset_sa_len: got %h want 0", {cfg_dma_sa, cfg_dma_len}); end
        @(negedge clk);
        req_valid = '0;
        reset = 1'b0;
        #1;
        n_vec++; if ({busy, req_ready} !== 5'b0) begin n_bad++; $display("FAIL reset_release_idle: got %b want 00000", {busy, req_ready}); end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_sa[0] = 32'h1000; req_len[0] = 32'h400; req_valid = 4'b0001; cfg_dma_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_vec++; if ({cfg_dma_valid, cfg_dma_sa, cfg_dma_len} !== {1'b1, 32'h1000, 32'h400})
            begin n_bad++; $display("FAIL single_issue: got %b %h %h want 1 00001000 00000400", cfg_dma_valid, cfg_dma_sa, cfg_dma_len); end
        @(negedge clk);
        cfg_dma_ready = 1'b0;
        #1;
        n_vec++; if ({cfg_dma_valid, busy} !== 2'b01) begin n_bad++; $display("FAIL single_handshake: valid,busy got %b want 01", {cfg_dma_valid, busy}); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (done !== 4'b0000) begin n_bad++; $display("FAIL single_early_done: cycle %0d got %b want 0000", i, done); end
        end
        @(negedge clk);
        cfg_dma_ready = 1'b1;
        #1;
        n_vec++; if (done !== 4'b0000) begin n_bad++; $display("FAIL single_done_at_rise: got %b want 0000", done); end
        step();
        n_vec++; if ({done, err} !== {4'b0001, 4'b0000}) begin n_bad++; $display("FAIL single_done: done,err got %b want 00010000", {done, err}); end
        step();
        n_vec++; if ({done, busy} !== 5'b00000) begin n_bad++; $display("FAIL single_pulse_width: done,busy got %b want 00000", {done, busy}); end
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        req_sa[2] = 32'h2000; req_len[2] = 32'h0; req_valid = 4'b0100;
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL zero_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_vec++; if ({done, err, cfg_dma_valid} !== {4'b0100, 4'b0000, 1'b0})
            begin n_bad++; $display("FAIL zero_done: done,err,valid got %b want 010000000", {done, err, cfg_dma_valid}); end
        step();
        n_vec++; if ({done, busy, cfg_dma_valid} !== 6'b0) begin n_bad++; $display("FAIL zero_after: got %b want 000000", {done, busy, cfg_dma_valid}); end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        req_sa[1] = 32'h1004; req_len[1] = 32'h100; req_valid = 4'b0010;
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL misal_sa_grant: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_vec++; if ({done, err, cfg_dma_valid} !== {4'b0010, 4'b0010, 1'b0})
            begin n_bad++; $display("FAIL misal_sa_done: done,err,valid got %b want 001000100", {done, err, cfg_dma_valid}); end
        @(negedge clk);
        req_sa[1] = 32'h1000; req_len[1] = 32'h104; req_valid = 4'b0010;
        #1;
        n_vec++; if ({req_ready, cfg_dma_valid} !== {4'b0010, 1'b0}) begin n_bad++; $display("FAIL misal_len_grant: got %b want 00100", {req_ready, cfg_dma_valid}); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_vec++; if ({done, err, cfg_dma_valid} !== {4'b0010, 4'b0010, 1'b0})
            begin n_bad++; $display("FAIL misal_len_done: done,err,valid got %b want 001000100", {done, err, cfg_dma_valid}); end
        step();
        n_vec++; if ({done, err, cfg_dma_valid} !== 9'b0) begin n_bad++; $display("FAIL misal_after: got %b want 000000000", {done, err, cfg_dma_valid}); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        cfg_dma_ready = 1'b0;
        req_sa[2] = 32'h4000; req_len[2] = 32'h800; req_valid = 4'b0100;
        req_sa[0] = 32'h100; req_len[0] = 32'h40;
        req_sa[1] = 32'h200; req_len[1] = 32'h40;
        req_sa[3] = 32'h300; req_len[3] = 32'h40;
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b1011;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            n_vec++; if ({cfg_dma_valid, cfg_dma_sa, cfg_dma_len, req_ready} !== {1'b1, 32'h4000, 32'h800, 4'b0000})
                begin n_bad++; $display("FAIL bp_hold: cycle %0d valid %b sa %h len %h ready %b want 1 00004000 00000800 0000", i, cfg_dma_valid, cfg_dma_sa, cfg_dma_len, req_ready); end
        end
        @(negedge clk);
        req_valid = '0;
        cfg_dma_ready = 1'b1;
        #1;
        n_vec++; if (cfg_dma_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_before_hs: got %b want 1", cfg_dma_valid); end
        @(negedge clk);
        cfg_dma_ready = 1'b0;
        #1;
        n_vec++; if (cfg_dma_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_after_hs: got %b want 0", cfg_dma_valid); end
        @(negedge clk);
        cfg_dma_ready = 1'b1;
        step();
        n_vec++; if ({done, err} !== {4'b0100, 4'b0000}) begin n_bad++; $display("FAIL bp_done: done,err got %b want 01000000", {done, err}); end
        step();
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] exp_oh;
        int             exp;
        @(negedge clk);
        reset = 1'b1;
        cfg_dma_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            req_sa[i]  = 32'h1000 << i;
            req_len[i] = 32'h100 * (i + 1);
        end
        req_valid = 4'b1111;
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp    = k % NCH;
            exp_oh = NCH'(1) << exp;
            n_vec++; if (req_ready !== exp_oh) begin n_bad++; $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready, exp_oh); end
            @(negedge clk);
            if (k == 4) req_valid = '0;
            #1;
            n_vec++; if ({cfg_dma_valid, cfg_dma_sa, req_ready} !== {1'b1, 32'h1000 << exp, 4'b0000})
                begin n_bad++; $display("FAIL rr_issue_%0d: valid %b sa %h ready %b want 1 %h 0000", k, cfg_dma_valid, cfg_dma_sa, req_ready, 32'h1000 << exp); end
            @(negedge clk);
            cfg_dma_ready = 1'b0;
            @(negedge clk);
            cfg_dma_ready = 1'b1;
            step();
            n_vec++; if ({done, req_ready} !== {exp_oh, 4'b0000}) begin n_bad++; $display("FAIL rr_done_%0d: done,ready got %b want %b0000", k, {done, req_ready}, exp_oh); end
            step();
        end
        n_vec++; if ({busy, req_ready} !== 5'b0) begin n_bad++; $display("FAIL rr_end_idle: got %b want 00000", {busy, req_ready}); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_sa[1] = 32'h3000; req_len[1] = 32'h200; req_valid = 4'b0010; cfg_dma_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL rstmid_grant: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        cfg_dma_ready = 1'b0;
        #1;
        n_vec++; if ({busy, cfg_dma_valid} !== 2'b10) begin n_bad++; $display("FAIL rstmid_wait: busy,valid got %b want 10", {busy, cfg_dma_valid}); end
        step();
        #2;
        reset = 1'b1;
        cfg_dma_ready = 1'b1;
        #1;
        n_vec++; if ({busy, cfg_dma_valid, done, err, req_ready, cfg_dma_sa, cfg_dma_len} !== '0)
            begin n_bad++; $display("FAIL rstmid_async: busy %b valid %b done %b err %b sa %h len %h want all 0", busy, cfg_dma_valid, done, err, cfg_dma_sa, cfg_dma_len); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++; if ({done, busy} !== 5'b0) begin n_bad++; $display("FAIL rstmid_no_done: done,busy got %b want 00000", {done, busy}); end
        step();
        n_vec++; if ({done, busy} !== 5'b0) begin n_bad++; $display("FAIL rstmid_no_done2: done,busy got %b want 00000", {done, busy}); end
        @(negedge clk);
        req_sa[3] = 32'h5000; req_len[3] = 32'h100; req_valid = 4'b1000;
        #1;
        n_vec++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL rstmid_ch3_grant: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_vec++; if ({cfg_dma_valid, cfg_dma_sa, cfg_dma_len} !== {1'b1, 32'h5000, 32'h100})
            begin n_bad++; $display("FAIL rstmid_ch3_issue: got %b %h %h want 1 00005000 00000100", cfg_dma_valid, cfg_dma_sa, cfg_dma_len); end
        @(negedge clk);
        cfg_dma_ready = 1'b0;
        @(negedge clk);
        cfg_dma_ready = 1'b1;
        step();
        n_vec++; if ({done, err} !== {4'b1000, 4'b0000}) begin n_bad++; $display("FAIL rstmid_ch3_done: done,err got %b want 10000000", {done, err}); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_misaligned();
        test_backpressure();
        test_round_robin();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
